regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file. It replaces the fixed 32×32, two-read-port register file in the lab top levels and is the datapath storage for the upcoming single-cycle and pipelined processor labs. Compared with that file it adds three things: a valid/ready write handshake, a sequential clear engine that zeroes every entry after reset or on request, and optional write-to-read bypass.

## Interface
- `WIDTH`, 32, data bits per register.
- `DEPTH`, 32, number of registers; power of two, at least 2. `AW = $clog2(DEPTH)`.
- `NUM_RD`, 2, number of combinational read ports, at least 1.
- `ZERO_REG`, 1, when 1, register 0 is read-only zero.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  level request to start a full clear.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write can be accepted this cycle.
- `wr_addr`  in  AW  write register index.
- `wr_data`  in  WIDTH  write data.
- `rd_addr`  in  NUM_RD*AW  packed read indices; port i is `[i*AW +: AW]`.
- `rd_data`  out  NUM_RD*WIDTH  packed read data; port i is `[i*WIDTH +: WIDTH]`.
- `busy`  out  1  clear engine active.
- `wr_err`  out  1  sticky flag: a write to register 0 was accepted while `ZERO_REG`=1.

## Operation
- Two-state FSM: CLEAR and IDLE.
- **CLEAR**
  - An AW-bit pointer `ptr` writes 0 into `mem[ptr]` every cycle, then increments.
  - After the cycle with `ptr == DEPTH-1`, the FSM moves to IDLE and `ptr` wraps to 0.
  - `busy` = 1 and `wr_ready` = 0 throughout.
  - `clr` asserted during CLEAR restarts the sweep: `ptr` returns to 0 on the next edge.
- **IDLE**
  - `busy` = 0 and `wr_ready` = 1.
  - A write is accepted when `wr_valid && wr_ready`; `mem[wr_addr]` updates on that edge.
  - `clr` asserted moves the FSM to CLEAR on the next edge. Any write presented in the same cycle is still accepted, and the sweep then overwrites it.
- **Reads**
  - Each port is combinational: `rd_data[i] = mem[rd_addr[i]]`.
  - The port returns 0 when `ZERO_REG` = 1 and the address is 0.
  - All ports return 0 while `busy` = 1.
  - Several ports may read the same address; each gets an identical value.
- **Writes to register 0 with `ZERO_REG` = 1**
  - The write is accepted (handshake completes) and the storage is not modified.
  - `wr_err` is set; it clears only on `rst` or at the start of a CLEAR sweep.
- Addresses are always in range, because DEPTH is a power of two.

## Timing
- While `rst` is high: state = CLEAR, `ptr` = 0, `busy` = 1, `wr_ready` = 0, `wr_err` = 0, `rd_data` = 0.
- Sweep length:
  - Cycle 0 is the first cycle with `rst` low.
  - Cycles 0 through DEPTH-1 clear entries 0 through DEPTH-1.
  - From cycle DEPTH: `busy` = 0 and `wr_ready` = 1.
- Write latency:
  - A write accepted at edge N is visible on the read ports in cycle N+1.
  - With bypass enabled, it is also visible combinationally in cycle N.
- `rst` asserted mid-sweep or mid-write: the next edge forces the reset state. A pending write is dropped.
- `clr` has no effect while `rst` = 1.

## Configuration
- Macro: `REGFILE_MP_BYPASS_EN`.
- **Defined:** a read port whose address equals `wr_addr` while `wr_valid && wr_ready` returns `wr_data` in the same cycle.
  - The zero-register rule takes priority over bypass.
  - `busy` forcing reads to 0 also takes priority over bypass.
- **Undefined:** a read returns the old contents until the cycle after the write edge.

## Structure
- Package `regfile_mp_pkg` holds:
  - FSM typedef `rf_state_t` with values `RF_CLEAR` and `RF_IDLE`.
  - Defaults `RF_WIDTH_DEF` and `RF_DEPTH_DEF`.
- One sub-module, `regfile_mp_rdport`: read mux plus zero, busy and bypass override, instantiated `NUM_RD` times with a generate loop.
- The clear FSM, pointer, storage array and `wr_err` stay in `regfile_mp`.

## Test plan
- **Reset release, DEPTH = 32**
  - Stimulus: release `rst`.
  - Expect: `busy` high for exactly 32 cycles; `wr_ready` rises in cycle 32; all ports read 0.
- **Write then read**
  - Stimulus: write `0x DEADBEEF` to reg 5 at edge N; read on port 0 and port 1 with `rd_addr` = 5.
  - Expect: both ports show `0x DEADBEEF` in cycle N+1.
  - With the bypass macro defined, also expect `0x DEADBEEF` in cycle N.
- **Zero register, `ZERO_REG` = 1**
  - Stimulus: write `0x1234` to reg 0.
  - Expect: the handshake completes, `wr_err` becomes 1 on the next cycle, and reads of reg 0 return 0.
- **Restart during sweep**
  - Stimulus: pulse `clr` in sweep cycle 10.
  - Expect: `busy` stays high until 32 cycles after the restart edge.
  - Expect: previously written registers read 0 afterwards, and `wr_err` is cleared.
- **Reset mid-sweep with write pending**
  - Stimulus: assert `rst` in sweep cycle 7 while `wr_valid` = 1.
  - Expect: no write occurs, and the sweep restarts from entry 0 after `rst` is released.
- **Parameter variant: WIDTH = 16, DEPTH = 8, NUM_RD = 3**
  - Stimulus: write distinct values to regs 1–7; read them with three ports addressing 1, 4 and 7 simultaneously.
  - Expect: each port returns the value written to its register.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH_DEF = 32;
    localparam int RF_DEPTH_DEF = 32;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port: array mux with bypass, zero-register and busy overrides.
// Bypass from the accepted write is compiled in only with REGFILE_MP_BYPASS_EN.
module regfile_mp_rdport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic [AW-1:0]          rd_addr_i,
    input  logic [DEPTH*WIDTH-1:0] mem_i,
    input  logic                   busy_i,
    input  logic                   byp_vld_i,
    input  logic [AW-1:0]          byp_addr_i,
    input  logic [WIDTH-1:0]       byp_dat_i,
    output logic [WIDTH-1:0]       rd_data_o
);

    // Overrides are applied lowest priority first: bypass, zero register, busy.
    always_comb begin
        rd_data_o = mem_i[int'(rd_addr_i)*WIDTH +: WIDTH];
`ifdef REGFILE_MP_BYPASS_EN
        if (byp_vld_i && (byp_addr_i == rd_addr_i)) begin
            rd_data_o = byp_dat_i;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end
        if (busy_i) begin
            rd_data_o = '0;
        end
    end

`ifndef REGFILE_MP_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_vld_i, byp_addr_i, byp_dat_i};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with valid/ready write port, sequential clear engine and NUM_RD read ports.
// Optional same-cycle write-to-read bypass under REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic                    busy,
    output logic                    wr_err
);

    rf_state_t        state_q;
    logic [AW-1:0]    ptr_q;
    logic             busy_q;
    logic             wr_ready_q;
    logic             wr_err_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;

    logic wr_fire;
    logic wr_zero;

    assign wr_fire = wr_valid && wr_ready_q;
    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RF_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (clr) begin
                        ptr_q    <= '0;
                        wr_err_q <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == AW'(DEPTH-1)) begin
                            state_q    <= RF_IDLE;
                            busy_q     <= 1'b0;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (clr) begin
                        state_q    <= RF_CLEAR;
                        ptr_q      <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                        wr_err_q   <= 1'b0;
                    end else if (wr_fire && wr_zero) begin
                        wr_err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; the sweep that follows every reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_fire && !wr_zero) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar m = 0; m < DEPTH; m++) begin : g_flat
        assign mem_flat[m*WIDTH +: WIDTH] = mem_q[m];
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_mp_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_rdport (
            .rd_addr_i  (rd_addr[g*AW +: AW]),
            .mem_i      (mem_flat),
            .busy_i     (busy_q),
            .byp_vld_i  (wr_fire),
            .byp_addr_i (wr_addr),
            .byp_dat_i  (wr_data),
            .rd_data_o  (rd_data[g*WIDTH +: WIDTH])
        );
    end

    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default 32x32/2-port instance plus a 16x8/3-port variant.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst, clr, wr_valid, wr_ready, busy, wr_err;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .wr_err(wr_err)
    );

    // Variant instance
    logic        rst_b, clr_b, wr_valid_b, wr_ready_b, busy_b, wr_err_b;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic [8:0]  rd_addr_b;
    logic [47:0] rd_data_b;

    regfile_mp #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .clr(clr_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .busy(busy_b), .wr_err(wr_err_b)
    );

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] get_act(int sig);
        case (sig)
            0:  return rd_data[31:0];
            1:  return rd_data[63:32];
            2:  return {31'b0, busy};
            3:  return {31'b0, wr_ready};
            4:  return {31'b0, wr_err};
            10: return {16'b0, rd_data_b[15:0]};
            11: return {16'b0, rd_data_b[31:16]};
            12: return {16'b0, rd_data_b[47:32]};
            13: return {31'b0, busy_b};
            14: return {31'b0, wr_ready_b};
            default: return 'x;
        endcase
    endfunction

    // Monitor: drains all expectations queued for the current cycle on the falling edge.
    initial begin
        chk_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = get_act(e.sig);
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_v(input string name, input int sig, input logic [31:0] exp);
        chk_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BEEF = 32'hDEADBEEF;
    localparam logic [31:0] V9   = 32'hA5A50009;
    logic [15:0] tbl [8];

    initial begin
        tbl = '{16'h0000, 16'hA001, 16'hB012, 16'hC123, 16'hD234, 16'hE345, 16'hF456, 16'h1567};
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst_b = 1'b1; clr_b = 1'b0; wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
        tick(); tick();

        // Reset state
        expect_v("rst_busy", 2, 1);
        expect_v("rst_wr_ready", 3, 0);
        expect_v("rst_wr_err", 4, 0);
        expect_v("rst_rd0", 0, 0);
        tick();

        // Reset release: exactly DEPTH busy cycles
        rst = 1'b0;
        rd_addr = {5'd7, 5'd3};
        for (int c = 0; c < 32; c++) begin
            expect_v($sformatf("sweep_busy_c%0d", c), 2, 1);
            expect_v($sformatf("sweep_ready_c%0d", c), 3, 0);
            tick();
        end
        expect_v("sweep_done_busy", 2, 0);
        expect_v("sweep_done_ready", 3, 1);
        expect_v("sweep_done_rd0", 0, 0);
        expect_v("sweep_done_rd1", 1, 0);

        // Write then read on two ports of the same register
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = BEEF;
        rd_addr = {5'd5, 5'd5};
`ifdef REGFILE_MP_BYPASS_EN
        expect_v("wr_cycN_rd0", 0, BEEF);
        expect_v("wr_cycN_rd1", 1, BEEF);
`else
        expect_v("wr_cycN_rd0", 0, 0);
        expect_v("wr_cycN_rd1", 1, 0);
`endif
        tick();
        wr_addr = 5'd9; wr_data = V9;
        expect_v("wr_cycN1_rd0", 0, BEEF);
        expect_v("wr_cycN1_rd1", 1, BEEF);
        tick();
        wr_valid = 1'b0;
        rd_addr = {5'd5, 5'd9};
        expect_v("rd_r9_port0", 0, V9);
        expect_v("rd_r5_port1", 1, BEEF);
        tick();

        // Zero register write
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_addr = {5'd9, 5'd0};
        expect_v("z_handshake", 3, 1);
        expect_v("z_err_before", 4, 0);
        expect_v("z_rd_same_cycle", 0, 0);
        tick();
        wr_valid = 1'b0;
        expect_v("z_err_after", 4, 1);
        expect_v("z_rd_after", 0, 0);
        expect_v("z_other_reg", 1, V9);
        tick();

        // Clear request, then restart in sweep cycle 10
        clr = 1'b1;
        expect_v("clr_idle_busy", 2, 0);
        tick();
        clr = 1'b0;
        expect_v("clr_start_busy", 2, 1);
        expect_v("clr_start_err", 4, 0);
        expect_v("clr_start_rd", 1, 0);
        for (int c = 0; c < 10; c++) tick();
        clr = 1'b1;
        expect_v("restart_c10_busy", 2, 1);
        tick();
        clr = 1'b0;
        for (int c = 0; c < 32; c++) begin
            expect_v($sformatf("restart_busy_c%0d", c), 2, 1);
            tick();
        end
        rd_addr = {5'd5, 5'd9};
        expect_v("restart_done_busy", 2, 0);
        expect_v("restart_r9_zero", 0, 0);
        expect_v("restart_r5_zero", 1, 0);
        expect_v("restart_err", 4, 0);
        tick();

        // Reset in sweep cycle 7 with a write pending
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1; wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BAD0BAD;
        expect_v("rstmid_ready", 3, 0);
        tick();
        expect_v("rstmid_busy", 2, 1);
        expect_v("rstmid_ready_held", 3, 0);
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        rd_addr = {5'd12, 5'd12};
        for (int c = 0; c < 32; c++) begin
            expect_v($sformatf("rstmid_sweep_c%0d", c), 2, 1);
            tick();
        end
        expect_v("rstmid_done_busy", 2, 0);
        expect_v("rstmid_r12_p0", 0, 0);
        expect_v("rstmid_r12_p1", 1, 0);
        expect_v("rstmid_err", 4, 0);
        tick();

        // Variant: WIDTH=16, DEPTH=8, NUM_RD=3
        rst_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            expect_v($sformatf("b_sweep_c%0d", c), 13, 1);
            tick();
        end
        expect_v("b_sweep_done", 13, 0);
        expect_v("b_ready", 14, 1);
        for (int i = 1; i < 8; i++) begin
            wr_valid_b = 1'b1; wr_addr_b = 3'(i); wr_data_b = tbl[i];
            tick();
        end
        wr_valid_b = 1'b0;
        rd_addr_b = {3'd7, 3'd4, 3'd1};
        expect_v("b_p0_r1", 10, {16'b0, tbl[1]});
        expect_v("b_p1_r4", 11, {16'b0, tbl[4]});
        expect_v("b_p2_r7", 12, {16'b0, tbl[7]});
        tick();
        rd_addr_b = {3'd2, 3'd2, 3'd6};
        expect_v("b_p0_r6", 10, {16'b0, tbl[6]});
        expect_v("b_p1_r2", 11, {16'b0, tbl[2]});
        expect_v("b_p2_r2", 12, {16'b0, tbl[2]});
        tick();
        rd_addr_b = {3'd3, 3'd0, 3'd5};
        expect_v("b_p0_r5", 10, {16'b0, tbl[5]});
        expect_v("b_p1_r0", 11, 0);
        expect_v("b_p2_r3", 12, {16'b0, tbl[3]});
        tick();
        tick();

        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
